// File: rtl/bch_15_7_serial_decoder.sv
// Serial BCH(15,7,2) decoder: bit-serial syndrome collection,
// one-cycle locator solve, 15-cycle Chien search, held result.
module bch_15_7_serial_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] out_msg,
  output logic [1:0] out_nerr,
  output logic       out_uncorr,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    COLLECT,
    SOLVE,
    SEARCH,
    DONE
  } state_t;

  function automatic logic [3:0] gf_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_exp(
    input logic [3:0] e
  );
    logic [3:0] r;
    unique case (e)
      4'd0:    r = 4'h1;
      4'd1:    r = 4'h2;
      4'd2:    r = 4'h4;
      4'd3:    r = 4'h8;
      4'd4:    r = 4'h3;
      4'd5:    r = 4'h6;
      4'd6:    r = 4'hC;
      4'd7:    r = 4'hB;
      4'd8:    r = 4'h5;
      4'd9:    r = 4'hA;
      4'd10:   r = 4'h7;
      4'd11:   r = 4'hE;
      4'd12:   r = 4'hF;
      4'd13:   r = 4'hD;
      4'd14:   r = 4'h9;
      default: r = 4'h1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] gf_log(
    input logic [3:0] a
  );
    logic [3:0] r;
    unique case (a)
      4'h1:    r = 4'd0;
      4'h2:    r = 4'd1;
      4'h4:    r = 4'd2;
      4'h8:    r = 4'd3;
      4'h3:    r = 4'd4;
      4'h6:    r = 4'd5;
      4'hC:    r = 4'd6;
      4'hB:    r = 4'd7;
      4'h5:    r = 4'd8;
      4'hA:    r = 4'd9;
      4'h7:    r = 4'd10;
      4'hE:    r = 4'd11;
      4'hF:    r = 4'd12;
      4'hD:    r = 4'd13;
      4'h9:    r = 4'd14;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] gf_inv(
    input logic [3:0] a
  );
    return gf_exp(4'd15 - gf_log(a));
  endfunction

  state_t      state_q, state_d;
  logic [14:0] raw_q, raw_d;
  logic [14:0] err_q, err_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s3_q, s3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  j_q, j_d;
  logic [3:0]  sig1_q, sig1_d;
  logic [3:0]  sig2_q, sig2_d;
  logic [1:0]  e_q, e_d;
  logic        flag_q, flag_d;
  logic [1:0]  roots_q, roots_d;
  logic [6:0]  msg_q, msg_d;
  logic [1:0]  nerr_q, nerr_d;
  logic        unc_q, unc_d;
  logic        ov_q, ov_d;

  logic [3:0]  s1_cube;
  logic [4:0]  j2;
  logic [3:0]  loc_val;
  logic [14:0] corr;
  logic        fail;

  assign s1_cube = gf_mul(gf_mul(s1_q, s1_q), s1_q);
  assign j2      = ({1'b0, j_q} << 1) >= 5'd15
                 ? ({1'b0, j_q} << 1) - 5'd15
                 : ({1'b0, j_q} << 1);
  assign loc_val = gf_exp(j2[3:0])
                 ^ gf_mul(sig1_q, gf_exp(j_q))
                 ^ sig2_q;
  assign corr    = raw_q ^ err_q;
  assign fail    = flag_q | (roots_q != e_q);

  assign in_ready   = (state_q == COLLECT);
  assign out_msg    = msg_q;
  assign out_nerr   = nerr_q;
  assign out_uncorr = unc_q;
  assign out_valid  = ov_q;

  // Next-state and datapath updates for each decoder phase
  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    err_d   = err_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    sig1_d  = sig1_q;
    sig2_d  = sig2_q;
    e_d     = e_q;
    flag_d  = flag_q;
    roots_d = roots_q;
    msg_d   = msg_q;
    nerr_d  = nerr_q;
    unc_d   = unc_q;
    ov_d    = ov_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          raw_d = {raw_q[13:0], in_bit};
          s1_d  = gf_mul(s1_q, 4'h2) ^ {3'b0, in_bit};
          s3_d  = gf_mul(s3_q, 4'h8) ^ {3'b0, in_bit};
          if (cnt_q == 4'd14) begin
            cnt_d   = 4'd0;
            state_d = SOLVE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SOLVE: begin
        sig1_d  = s1_q;
        sig2_d  = (s1_q != 4'h0)
                ? gf_mul(s3_q ^ s1_cube, gf_inv(s1_q))
                : 4'h0;
        if (s1_q == 4'h0 && s3_q == 4'h0)
          e_d = 2'd0;
        else if (s1_q != 4'h0 && s3_q == s1_cube)
          e_d = 2'd1;
        else
          e_d = 2'd2;
        flag_d  = (s1_q == 4'h0) && (s3_q != 4'h0);
        err_d   = 15'h0;
        roots_d = 2'd0;
        j_d     = 4'd0;
        state_d = SEARCH;
      end
      SEARCH: begin
        if (loc_val == 4'h0) begin
          err_d   = err_q | (15'd1 << j_q);
          roots_d = (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
        end
        if (j_q == 4'd14) begin
          j_d     = 4'd0;
          state_d = DONE;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      DONE: begin
        if (!ov_q) begin
          ov_d   = 1'b1;
          unc_d  = fail;
          msg_d  = fail ? raw_q[14:8] : corr[14:8];
          nerr_d = fail ? 2'd0 : e_q;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = COLLECT;
          s1_d    = 4'h0;
          s3_d    = 4'h0;
          cnt_d   = 4'd0;
          j_d     = 4'd0;
          roots_d = 2'd0;
          err_d   = 15'h0;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      raw_q   <= '0;
      err_q   <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      sig1_q  <= '0;
      sig2_q  <= '0;
      e_q     <= '0;
      flag_q  <= 1'b0;
      roots_q <= '0;
      msg_q   <= '0;
      nerr_q  <= '0;
      unc_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      err_q   <= err_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      sig1_q  <= sig1_d;
      sig2_q  <= sig2_d;
      e_q     <= e_d;
      flag_q  <= flag_d;
      roots_q <= roots_d;
      msg_q   <= msg_d;
      nerr_q  <= nerr_d;
      unc_q   <= unc_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_bch_15_7_serial_decoder.sv
// Bench for the serial BCH(15,7,2) decoder: directed table,
// handshake/reset corner cases, random words vs nearest-codeword model.
module tb_bch_15_7_serial_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] out_msg;
  logic [1:0] out_nerr;
  logic       out_uncorr;
  logic       out_valid;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  bch_15_7_serial_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_msg    (out_msg),
    .out_nerr   (out_nerr),
    .out_uncorr (out_uncorr),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] rx;
    logic [6:0]  msg;
    logic [1:0]  nerr;
    logic        unc;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // systematic encoder by polynomial long division
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] r;
    r = {m, 8'h00};
    for (int b = 14; b >= 8; b--)
      if (r[b]) r = r ^ (15'h1D1 << (b - 8));
    return {m, r[7:0]};
  endfunction

  // nearest codeword search: radius 2 decodes, else flagged
  task automatic model(input logic [14:0] rx, output logic [6:0] m,
                       output logic [1:0] ne, output logic u);
    int best = 99;
    int bm = 0;
    for (int k = 0; k < 128; k++) begin
      int d = $countones(encode(7'(k)) ^ rx);
      if (d < best) begin
        best = d;
        bm = k;
      end
    end
    if (best <= 2) begin
      m  = 7'(bm);
      ne = 2'(best);
      u  = 1'b0;
    end else begin
      m  = rx[14:8];
      ne = 2'd0;
      u  = 1'b1;
    end
  endtask

  task automatic send_word(input logic [14:0] rx, input bit gaps,
                           input int nbits);
    int i = 14;
    int sent = 0;
    int guard = 0;
    bit acc;
    while (sent < nbits) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_bit   = rx[i];
      acc      = in_valid && in_ready;
      tick;
      if (acc) begin
        i--;
        sent++;
      end
      guard++;
      if (guard > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [14:0] rx,
                         input logic [6:0] m, input logic [1:0] ne,
                         input logic u, input bit gaps, input int stall);
    int n;
    out_ready = 1'b0;
    send_word(rx, gaps, 15);
    wait_valid(n);
    chk({tag, "_lat"}, n, 17);
    chk({tag, "_msg"}, out_msg, m);
    chk({tag, "_nerr"}, out_nerr, ne);
    chk({tag, "_unc"}, out_uncorr, u);
    repeat (stall) begin
      tick;
      chk({tag, "_hold"},
          {out_valid, in_ready, out_msg, out_nerr, out_uncorr},
          {1'b1, 1'b0, m, ne, u});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int n;
    bit seen;
    logic [14:0] rx;
    logic [6:0] m;
    logic [1:0] ne;
    logic u;

    tbl[0] = '{15'h40E8, 7'h40, 2'd0, 1'b0};
    tbl[1] = '{15'h4000, 7'h00, 2'd1, 1'b0};
    tbl[2] = '{15'h02E8, 7'h40, 2'd2, 1'b0};
    tbl[3] = '{15'h0013, 7'h00, 2'd0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_msg, out_nerr, out_uncorr}, 0);

    for (int k = 0; k < 4; k++)
      run_vec($sformatf("tbl%0d", k), tbl[k].rx, tbl[k].msg,
              tbl[k].nerr, tbl[k].unc, 1'b0, 2);

    run_vec("stall", 15'h40E8, 7'h40, 2'd0, 1'b0, 1'b1, 10);

    out_ready = 1'b1;
    send_word(15'h02E8, 1'b0, 15);
    wait_valid(n);
    chk("early_rdy_lat", n, 17);
    chk("early_rdy_out", {out_msg, out_nerr, out_uncorr},
        {7'h40, 2'd2, 1'b0});
    tick;
    out_ready = 1'b0;
    chk("early_rdy_rel", {out_valid, in_ready}, 2'b01);

    send_word(15'h40E8, 1'b0, 9);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midword_rst_rdy", in_ready, 1);
    run_vec("after_rst", 15'h4000, 7'h00, 2'd1, 1'b0, 1'b0, 1);

    send_word(15'h4000, 1'b0, 15);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    chk("search_rst_ov", seen, 0);
    chk("search_rst_rdy", in_ready, 1);

    send_word(15'h02E8, 1'b0, 15);
    wait_valid(n);
    out_ready = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    out_ready = 1'b0;
    chk("rst_prio",
        {out_valid, in_ready, out_msg, out_nerr, out_uncorr},
        {1'b0, 1'b1, 7'h00, 2'd0, 1'b0});

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        rx = 15'($urandom);
      end else begin
        rx = encode(7'($urandom_range(0, 127)));
        repeat ($urandom_range(0, 4)) rx[$urandom_range(0, 14)] ^= 1'b1;
      end
      model(rx, m, ne, u);
      run_vec($sformatf("rnd%0d", k), rx, m, ne, u,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bch_15_7_serial_decoder.md
BCH_15_7_SERIAL_DECODER -- requirements
Module: bch_15_7_serial_decoder

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `in_bit`, input, 1 bit: received codeword bit, MSB (x^14 coefficient) first.
REQ-005 SHALL have port `in_valid`, input, 1 bit: `in_bit` is valid.
REQ-006 SHALL have port `in_ready`, output, 1 bit: decoder accepts a bit this cycle.
REQ-007 SHALL have port `out_msg`, output, 7 bits: decoded message, i.e. codeword bits [14:8].
REQ-008 SHALL have port `out_nerr`, output, 2 bits: number of corrected errors (0, 1 or 2).
REQ-009 SHALL have port `out_uncorr`, output, 1 bit: uncorrectable pattern detected.
REQ-010 SHALL have port `out_valid`, output, 1 bit: result valid.
REQ-011 SHALL have port `out_ready`, input, 1 bit: consumer accepts the result.

Function
REQ-012 SHALL use the code BCH(15,7,2): generator 0x1D1 (x^8+x^7+x^6+x^4+1), GF(16) built on x^4+x+1 (alpha^4 = 0x3); codeword bits [14:8] hold the message, bits [7:0] hold parity.
REQ-013 SHALL be implemented as an FSM with states COLLECT, SOLVE, SEARCH and DONE; after reset the FSM SHALL be in COLLECT.
REQ-014 SHALL drive `in_ready` = 1 only in COLLECT; a bit is accepted only when `in_valid` and `in_ready` are both high.
REQ-015 SHALL, while `in_valid` is low, consume no bit and change no state.
REQ-016 SHALL, in COLLECT, on each accepted bit: shift the bit into a 15-bit raw register; update S1 = S1*alpha ^ bit and S3 = S3*alpha^3 ^ bit (Horner form, GF(16)); increment a 4-bit bit counter.
REQ-017 SHALL, on the 15th accepted bit, clear the bit counter and move to SOLVE on the next edge.
REQ-018 SHALL, in SOLVE (1 cycle), compute the error locator and move to SEARCH:
  - sigma1 = S1;
  - sigma2 = (S3 ^ S1^3) / S1 when S1 != 0, otherwise 0;
  - expected roots E = 0 if S1 = S3 = 0; E = 1 if S1 != 0 and S3 = S1^3; E = 2 otherwise;
  - S1 = 0 with S3 != 0 SHALL set an internal uncorrectable flag.
REQ-019 SHALL, in SEARCH (exactly 15 cycles, j = 0..14, one position per cycle):
  - evaluate alpha^(2j) ^ sigma1*alpha^j ^ sigma2;
  - on a zero result, flip raw bit j and increment a root counter (saturating at 3);
  - the j counter wraps 14 -> 0 on exit to DONE.
REQ-020 SHALL, on entering DONE, register the outputs:
  - `out_uncorr` = flag OR (root count != E);
  - when `out_uncorr` = 1: `out_msg` = the raw, uncorrected bits [14:8] and `out_nerr` = 0;
  - otherwise: `out_msg` = corrected bits [14:8] and `out_nerr` = E.
REQ-021 SHALL hold `out_valid` = 1 and all result outputs stable in DONE until `out_ready` = 1.
REQ-022 SHALL, on the cycle where `out_valid` and `out_ready` are both high, clear `out_valid` and return to COLLECT with S1, S3 and all counters cleared; `in_ready` rises the next cycle, with no overlap with DONE.
REQ-023 SHALL have a fixed latency: edge accepting bit 15 -> `out_valid` high 17 edges later (1 SOLVE + 15 SEARCH + 1 register), independent of error count.
REQ-024 SHALL ignore `out_ready` outside DONE.
REQ-025 SHALL perform all GF(16) multiply, inverse and log operations as combinational logic using 4-bit values; exponent arithmetic is taken mod 15.

Reset
REQ-026 SHALL, on `rst` = 1 at a clock edge, reach in that same edge from any state, including mid-word or mid-SEARCH:
  - state = COLLECT;
  - `in_ready` = 1 the cycle after;
  - `out_valid` = 0, `out_msg` = 0, `out_nerr` = 0, `out_uncorr` = 0;
  - S1, S3, raw register and all counters = 0;
  - any partial word discarded.
REQ-027 SHALL give `rst` priority over every simultaneous handshake event.

Verification
REQ-028 SHALL cover no errors: codeword 0x40E8 with `in_valid` held high -> `out_msg` = 0x40, `out_nerr` = 0, `out_uncorr` = 0; `out_valid` high 17 edges after the last bit.
REQ-029 SHALL cover a single error: received 0x4000 (zero codeword, bit 14 flipped) -> `out_msg` = 0x00, `out_nerr` = 1, `out_uncorr` = 0.
REQ-030 SHALL cover a double error: received 0x02E8 (0x40E8 with bits 14 and 9 flipped) -> `out_msg` = 0x40, `out_nerr` = 2, `out_uncorr` = 0.
REQ-031 SHALL cover an uncorrectable pattern: received 0x0013 (errors at bits 0, 1, 4; S1 = 0, S3 = 0x6) -> `out_uncorr` = 1, `out_msg` = 0x00, `out_nerr` = 0.
REQ-032 SHALL cover backpressure and stalls:
  - 0x40E8 sent with random `in_valid` gaps -> same result as REQ-028;
  - `out_ready` held low for 10 cycles -> outputs stable, `in_ready` = 0;
  - `out_ready` = 1 -> `in_ready` = 1 the next cycle.
REQ-033 SHALL cover reset mid-operation: `rst` after 9 bits, then a full 0x4000 -> result identical to REQ-029; `rst` during SEARCH -> `out_valid` never asserts.
